// File: rtl/bus_arb_2m.sv
// rtl/bus_arb_2m.sv - two-master to one-slave req/ack/resp bus arbiter
// Grants one master per cycle and routes read responses back by an in-order ID FIFO.
module bus_arb_2m #(
    parameter int fixed_prio   = 0,
    parameter int rdfifo_depth = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic        err_o
);

    localparam int PW = $clog2(rdfifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(rdfifo_depth);

    logic [rdfifo_depth-1:0] id_fifo_q, id_fifo_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    last_grant_q, last_grant_d;
    logic                    err_q, err_d;

    logic fifo_full, fifo_empty;
    logic m0_elig, m1_elig;
    logic win_valid, win_id;
    logic xfer, push, pop, head_id;

    // Full is the registered count: a response popping this cycle cannot free a slot for a read now.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign m0_elig    = m0_req_i & (m0_we_i | ~fifo_full);
    assign m1_elig    = m1_req_i & (m1_we_i | ~fifo_full);
    assign head_id    = id_fifo_q[rd_ptr_q];

    always_comb begin
        win_valid = m0_elig | m1_elig;
        win_id    = 1'b0;
        if (m0_elig && m1_elig) begin
            if (fixed_prio != 0) begin
                win_id = 1'b0;
            end else begin
                win_id = ~last_grant_q;
            end
        end else if (m1_elig) begin
            win_id = 1'b1;
        end
    end

    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        if (win_valid) begin
            if (win_id) begin
                s_req_o    = m1_req_i;
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
                m1_ack_o   = s_ack_i;
            end else begin
                s_req_o    = m0_req_i;
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
                m0_ack_o   = s_ack_i;
            end
        end
    end

    // Responses with nothing outstanding are dropped here and only flagged through err_o.
    always_comb begin
        m0_resp_o   = 1'b0;
        m1_resp_o   = 1'b0;
        m0_rdata_bo = '0;
        m1_rdata_bo = '0;
        if (!fifo_empty) begin
            if (head_id) begin
                m1_resp_o   = s_resp_i;
                m1_rdata_bo = s_rdata_bi;
            end else begin
                m0_resp_o   = s_resp_i;
                m0_rdata_bo = s_rdata_bi;
            end
        end
    end

    assign xfer = s_req_o & s_ack_i;
    assign push = xfer & ~s_we_o;
    assign pop  = s_resp_i & ~fifo_empty;

    always_comb begin
        id_fifo_d    = id_fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (s_resp_i & fifo_empty);
        if (xfer) begin
            last_grant_d = win_id;
        end
        if (push) begin
            id_fifo_d[wr_ptr_q] = win_id;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read when count_q covers them.
    always_ff @(posedge clk_i) begin
        id_fifo_q <= id_fifo_d;
    end

    assign err_o = err_q;

endmodule

// File: doc/bus_arb_2m.md
Name: bus_arb_2m

Overview:
- Two-master to one-slave arbiter for the request/ack/resp memory bus. It sits directly upstream of the bus unit's data port.
- Master 0 is the UDM debug bus. Master 1 is the CPU data port.
- Grants the slave port to one master per cycle, either round-robin or fixed-priority.
- Tracks outstanding reads in an in-order ID FIFO, so each read response is routed only to the master that issued it. The slave may have several reads in flight.

Parameters:
- fixed_prio, 0: 0 = round-robin between masters; 1 = master 0 always wins.
- rdfifo_depth, 4: maximum outstanding accepted reads. Power of two, 2..16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- m0_req_i  in  1  master 0 request
- m0_we_i  in  1  master 0 write enable
- m0_addr_bi  in  32  master 0 address
- m0_be_bi  in  4  master 0 byte enables
- m0_wdata_bi  in  32  master 0 write data
- m0_ack_o  out  1  master 0 request accepted
- m0_resp_o  out  1  master 0 read data valid
- m0_rdata_bo  out  32  master 0 read data
- m1_*  same set of eight ports as m0_*, for master 1
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_bo  out  32  slave address
- s_be_bo  out  4  slave byte enables
- s_wdata_bo  out  32  slave write data
- s_ack_i  in  1  slave accepted
- s_resp_i  in  1  slave read data valid
- s_rdata_bi  in  32  slave read data
- err_o  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Bus protocol:
  - A transfer occurs on a cycle with req & ack.
  - Only reads produce a response: exactly one s_resp_i pulse, in acceptance order, at least 1 cycle after ack.
  - A master holds req and all its fields stable until ack.
- Grant is combinational, computed each cycle from the current requests:
  - Eligible: a master with req=1, AND (we=1 OR the FIFO is not full).
  - One eligible master: it wins.
  - Both eligible, fixed_prio=1: m0 wins.
  - Both eligible, fixed_prio=0: the master that is not last_grant wins.
- Slave outputs:
  - The winner's req/we/addr/be/wdata drive s_*.
  - With no winner, all s_* outputs are 0.
  - s_ack_i is forwarded only to the winner's ack. The other master's ack is 0.
- last_grant (1 bit register):
  - Updates to the winner ID on each cycle with s_req_o & s_ack_i.
  - Reset value is 1, so m0 wins the first contention.
- ID FIFO:
  - Depth rdfifo_depth, 1-bit entries. Write/read pointers of log2(depth) bits that wrap, plus a count register of log2(depth)+1 bits.
  - Push the winner ID on s_req_o & s_ack_i & ~s_we_o.
  - Pop on s_resp_i when count != 0.
  - Full means count == rdfifo_depth, registered value. A same-cycle pop does not unblock a read grant.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Response routing (combinational):
  - The head ID selects the target: m<head>_resp_o = s_resp_i and m<head>_rdata_bo = s_rdata_bi.
  - The non-selected master gets resp=0 and rdata=0.
  - FIFO empty: both resp=0 and both rdata=0.
- Error case, s_resp_i with count == 0:
  - Response is dropped, no pop.
  - err_o is set and held until reset.
- Writes never enter the FIFO. A write may be granted while reads are outstanding or while the FIFO is full.
- Reset, synchronous on rst_i=1:
  - Pointers and count go to 0, last_grant to 1, err_o to 0.
  - Reads in flight at reset are forgotten. Their later responses set err_o unless the slave is reset together with the arbiter.
- Latency: zero-cycle combinational path for request, ack and response. No added pipeline stages.

Test Plan:
- Only m1 read to addr 0x100: s_addr_bo=0x100; m1_ack_o mirrors s_ack_i. A response with rdata 0xDEADBEEF appears on m1_rdata_bo with m1_resp_o=1, and m0_resp_o=0.
- fixed_prio=0, both hold reads with ack each cycle: grants alternate m0,m1,m0,m1. Responses 1,2,3,4 route to m0,m1,m0,m1 respectively.
- fixed_prio=1, both request for 3 cycles: m0 granted every cycle, m1_ack_o=0 throughout.
- rdfifo_depth=4, m1 issues 4 reads with no responses: 5th read gets no grant (s_req_o=0). An m0 write is still granted. After one response, the next cycle grants the read.
- Push and pop in the same cycle with count=2: count stays 2 and routing order is preserved.
- s_resp_i pulse after reset with no reads outstanding: err_o goes 1 on the next edge and stays 1. Both resp outputs are 0. Asserting rst_i clears err_o.
